sprite_anim_rom: RTL

Parametrised, multi-frame sprite ROM with a built-in animation sequencer and a registered read port. It stores FRAMES bitmaps of HEIGHT rows by WIDTH bits each. It advances the displayed frame every TICKS_PER_FRAME vertical-sync ticks and serves one row per read request with 1-cycle latency. Sits between the enemy/ship position logic and the colour mapper; the colour mapper issues row reads during active video.

---
 rtl/sprite_anim_rom.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sprite_anim_rom.sv
// sprite_anim_rom
//   Multi-frame sprite bitmap ROM with an animation sequencer and a registered
//   row read port. The frame index advances every TICKS_PER_FRAME frame_tick
//   pulses while anim_en is high; frame_load forces a frame directly.
//
// Ports:
//   Clk         system clock, rising edge
//   Reset_n     asynchronous active-low reset
//   frame_tick  one-cycle pulse per video frame
//   anim_en     1 = sequencer advances on frame_tick
//   frame_load  one-cycle strobe: cur_frame <= frame_sel (saturated)
//   frame_sel   frame index to load
//   rd_en       row read request
//   row_addr    row within the current frame
//   mirror      1 = return the row bit-reversed
//   data_out    registered row data (1-cycle latency)
//   data_valid  high one cycle after an accepted rd_en
//   cur_frame   current frame index
//   anim_wrap   one-cycle pulse on auto-advance wrap FRAMES-1 -> 0
module sprite_anim_rom #(
  parameter int WIDTH           = 8,
  parameter int HEIGHT          = 8,
  parameter int FRAMES          = 3,
  parameter int TICKS_PER_FRAME = 30,
  parameter int AW              = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  parameter int FW              = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  parameter logic [0:FRAMES*HEIGHT-1][WIDTH-1:0] ROM_INIT = {
    // frame A
    8'b11000011, 8'b01111110, 8'b11011011, 8'b11111111,
    8'b11111111, 8'b00100100, 8'b01011010, 8'b10000001,
    // frame B
    8'b00000000, 8'b00111100, 8'b01111110, 8'b11011011,
    8'b10100101, 8'b01111110, 8'b00100100, 8'b01000010,
    // frame C
    8'b00011000, 8'b00111100, 8'b01111110, 8'b11011011,
    8'b11111111, 8'b00100100, 8'b01011010, 8'b10100101
  }
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_tick,
  input  logic             anim_en,
  input  logic             frame_load,
  input  logic [FW-1:0]    frame_sel,
  input  logic             rd_en,
  input  logic [AW-1:0]    row_addr,
  input  logic             mirror,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [FW-1:0]    cur_frame,
  output logic             anim_wrap
);

  localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam int IW = (FRAMES * HEIGHT > 1) ? $clog2(FRAMES * HEIGHT) : 1;

  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [FW-1:0]    cur_frame_q, cur_frame_d;
  logic             anim_wrap_q, anim_wrap_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;

  logic [31:0]      rom_base;
  logic [IW-1:0]    rom_idx;
  logic             row_in_range;
  logic [WIDTH-1:0] row_data;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  // Row lookup uses the frame index as registered before this edge, so a read
  // issued alongside a frame change still returns the old frame. The base is
  // computed at 32 bits so cur_frame*HEIGHT cannot truncate.
  always_comb begin
    rom_base     = 32'(cur_frame_q) * 32'(HEIGHT) + 32'(row_addr);
    rom_idx      = IW'(rom_base);
    row_in_range = (32'(row_addr) < 32'(HEIGHT));
    row_data     = '0;
    if (row_in_range) row_data = ROM_INIT[rom_idx];
  end

  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    cur_frame_d  = cur_frame_q;
    anim_wrap_d  = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;

    // Load wins over auto-advance and is honoured even with anim_en low.
    if (frame_load) begin
      tick_cnt_d = '0;
      if (32'(frame_sel) > 32'(FRAMES - 1)) cur_frame_d = FW'(FRAMES - 1);
      else                                  cur_frame_d = frame_sel;
    end else if (anim_en && frame_tick) begin
      if (tick_cnt_q == TW'(TICKS_PER_FRAME - 1)) begin
        tick_cnt_d = '0;
        if (cur_frame_q == FW'(FRAMES - 1)) begin
          cur_frame_d = '0;
          anim_wrap_d = 1'b1;
        end else begin
          cur_frame_d = cur_frame_q + FW'(1);
        end
      end else begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end
    end

    if (rd_en) begin
      data_out_d   = mirror ? bit_rev(row_data) : row_data;
      data_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tick_cnt_q   <= '0;
      cur_frame_q  <= '0;
      anim_wrap_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      cur_frame_q  <= cur_frame_d;
      anim_wrap_q  <= anim_wrap_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign cur_frame  = cur_frame_q;
  assign anim_wrap  = anim_wrap_q;

endmodule
